// File: rtl/or_event_monitor.sv
// Activity monitor: registered OR-reduce of a line group, with a pulse stretcher,
// per-line sticky bits, a saturating rising-edge counter and a first-hit index.
module or_event_monitor #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned HOLD  = 4,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             clr,
    output logic             any_o,
    output logic             any_hold_o,
    output logic [WIDTH-1:0] sticky_o,
    output logic [CNT_W-1:0] evt_cnt_o,
    output logic             first_vld_o,
    output logic [IDX_W-1:0] first_idx_o
);

    localparam int unsigned HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StHold
    } state_t;

    state_t              r_state;
    state_t              w_state_d;
    logic [HCNT_W-1:0]   r_hcnt;
    logic [HCNT_W-1:0]   w_hcnt_d;
    logic                r_hold;
    logic                w_hold_d;

    logic                r_any;
    logic [WIDTH-1:0]    r_sticky;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_vld;
    logic [IDX_W-1:0]    r_idx;

    logic                w_or;
    logic                w_rise;
    logic [IDX_W-1:0]    w_low_idx;

    assign w_or   = |in_vec;
    assign w_rise = w_or & ~r_any;

    // Descending scan so the lowest set line wins.
    always_comb begin
        w_low_idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    // Stretcher FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_hcnt  <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_hcnt  <= w_hcnt_d;
            r_hold  <= w_hold_d;
        end
    end

    // Hold counter runs HOLD-1 down to 0, giving exactly HOLD extra cycles of any_hold_o.
    always_comb begin
        w_state_d = r_state;
        w_hcnt_d  = r_hcnt;
        w_hold_d  = r_hold;
        unique case (r_state)
            StIdle: begin
                if (w_or) begin
                    w_state_d = StActive;
                    w_hold_d  = 1'b1;
                end else begin
                    w_hold_d  = 1'b0;
                end
            end
            StActive: begin
                w_hold_d = 1'b1;
                if (!w_or) begin
                    if (HOLD == 0) begin
                        w_state_d = StIdle;
                        w_hold_d  = 1'b0;
                    end else begin
                        w_state_d = StHold;
                        w_hcnt_d  = HCNT_W'(HOLD - 1);
                    end
                end
            end
            StHold: begin
                w_hold_d = 1'b1;
                if (w_or) begin
                    w_state_d = StActive;
                    w_hcnt_d  = '0;
                end else if (r_hcnt == '0) begin
                    w_state_d = StIdle;
                    w_hold_d  = 1'b0;
                end else begin
                    w_hcnt_d  = r_hcnt - HCNT_W'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_hcnt_d  = '0;
                w_hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= w_or;
        end
    end

    // Clear restarts capture but still records whatever happens in the clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
            r_idx    <= '0;
        end else if (clr) begin
            r_sticky <= in_vec;
            r_cnt    <= w_rise ? CNT_W'(1) : '0;
            r_vld    <= w_rise;
            r_idx    <= w_rise ? w_low_idx : '0;
        end else begin
            r_sticky <= r_sticky | in_vec;
            if (w_rise && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_rise && !r_vld) begin
                r_vld <= 1'b1;
                r_idx <= w_low_idx;
            end
        end
    end

    assign any_o       = r_any;
    assign any_hold_o  = r_hold;
    assign sticky_o    = r_sticky;
    assign evt_cnt_o   = r_cnt;
    assign first_vld_o = r_vld;
    assign first_idx_o = r_idx;

endmodule

// File: tb/tb_or_event_monitor.sv
// Bench for or_event_monitor: directed vector table, hand sequences for reset,
// saturation and async reset, then random stimulus against a behavioural model.
module tb_or_event_monitor;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_vec;
    logic       clr;
    logic       any_o;
    logic       any_hold_o;
    logic [2:0] sticky_o;
    logic [7:0] evt_cnt_o;
    logic       first_vld_o;
    logic [1:0] first_idx_o;

    logic [2:0] sat_in;
    logic       sat_clr;
    logic       sat_any;
    logic       sat_hold;
    logic [2:0] sat_sticky;
    logic [1:0] sat_cnt;
    logic       sat_vld;
    logic [1:0] sat_idx;

    int total;
    int bad;

    or_event_monitor #(.WIDTH(3), .CNT_W(8), .HOLD(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vec     (in_vec),
        .clr        (clr),
        .any_o      (any_o),
        .any_hold_o (any_hold_o),
        .sticky_o   (sticky_o),
        .evt_cnt_o  (evt_cnt_o),
        .first_vld_o(first_vld_o),
        .first_idx_o(first_idx_o)
    );

    or_event_monitor #(.WIDTH(3), .CNT_W(2), .HOLD(0)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vec     (sat_in),
        .clr        (sat_clr),
        .any_o      (sat_any),
        .any_hold_o (sat_hold),
        .sticky_o   (sat_sticky),
        .evt_cnt_o  (sat_cnt),
        .first_vld_o(sat_vld),
        .first_idx_o(sat_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] in;
        logic       clr;
        logic       any;
        logic       hold;
        logic [2:0] sticky;
        logic [7:0] cnt;
        logic       vld;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mk(logic [2:0] in, logic c, logic a, logic h, logic [2:0] s,
                                logic [7:0] n, logic v, logic [1:0] x);
        vec_t r;
        r.in = in; r.clr = c; r.any = a; r.hold = h;
        r.sticky = s; r.cnt = n; r.vld = v; r.idx = x;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic a, input logic h, input logic [2:0] s,
                           input logic [7:0] n, input logic v, input logic [1:0] x);
        chk({tag, ".any"},    32'(any_o),       32'(a));
        chk({tag, ".hold"},   32'(any_hold_o),  32'(h));
        chk({tag, ".sticky"}, 32'(sticky_o),    32'(s));
        chk({tag, ".cnt"},    32'(evt_cnt_o),   32'(n));
        chk({tag, ".vld"},    32'(first_vld_o), 32'(v));
        chk({tag, ".idx"},    32'(first_idx_o), 32'(x));
    endtask

    // Reference model state: abstracted as "cycles since OR last sampled high".
    logic       m_any;
    int         m_since;
    logic [2:0] m_sticky;
    int         m_cnt;
    logic       m_vld;
    logic [1:0] m_idx;

    function automatic logic [1:0] lowest(logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_any = 1'b0; m_since = 1000; m_sticky = '0; m_cnt = 0; m_vld = 1'b0; m_idx = '0;
    endtask

    task automatic model_step(input logic [2:0] v, input logic c);
        logic o;
        logic rise;
        o    = |v;
        rise = o && !m_any;
        m_any = o;
        if (o) m_since = 0;
        else if (m_since < 1000) m_since++;
        if (c) begin
            m_sticky = v;
            m_cnt    = rise ? 1 : 0;
            m_vld    = rise;
            m_idx    = rise ? lowest(v) : 2'd0;
        end else begin
            m_sticky = m_sticky | v;
            if (rise && m_cnt < 255) m_cnt++;
            if (rise && !m_vld) begin
                m_vld = 1'b1;
                m_idx = lowest(v);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; in_vec = 3'b111; clr = 1'b0; sat_in = '0; sat_clr = 1'b0;

        // Reset with all lines high, then release.
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst", 1'b0, 1'b0, 3'b000, 8'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        step();
        chk_all("rel", 1'b1, 1'b1, 3'b111, 8'd1, 1'b1, 2'd0);

        // in, clr | any hold sticky cnt vld idx
        tbl[0]  = mk(3'b000, 1, 0, 1, 3'b000, 0, 0, 0);
        tbl[1]  = mk(3'b000, 0, 0, 1, 3'b000, 0, 0, 0);
        tbl[2]  = mk(3'b000, 0, 0, 1, 3'b000, 0, 0, 0);
        tbl[3]  = mk(3'b000, 0, 0, 1, 3'b000, 0, 0, 0);
        tbl[4]  = mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 0);
        tbl[5]  = mk(3'b010, 0, 1, 1, 3'b010, 1, 1, 1);
        tbl[6]  = mk(3'b010, 0, 1, 1, 3'b010, 1, 1, 1);
        tbl[7]  = mk(3'b000, 0, 0, 1, 3'b010, 1, 1, 1);
        tbl[8]  = mk(3'b000, 0, 0, 1, 3'b010, 1, 1, 1);
        tbl[9]  = mk(3'b000, 0, 0, 1, 3'b010, 1, 1, 1);
        tbl[10] = mk(3'b000, 0, 0, 1, 3'b010, 1, 1, 1);
        tbl[11] = mk(3'b000, 0, 0, 0, 3'b010, 1, 1, 1);
        tbl[12] = mk(3'b000, 1, 0, 0, 3'b000, 0, 0, 0);
        tbl[13] = mk(3'b010, 0, 1, 1, 3'b010, 1, 1, 1);
        tbl[14] = mk(3'b000, 0, 0, 1, 3'b010, 1, 1, 1);
        tbl[15] = mk(3'b000, 0, 0, 1, 3'b010, 1, 1, 1);
        tbl[16] = mk(3'b100, 0, 1, 1, 3'b110, 2, 1, 1);
        tbl[17] = mk(3'b000, 0, 0, 1, 3'b110, 2, 1, 1);
        tbl[18] = mk(3'b000, 0, 0, 1, 3'b110, 2, 1, 1);
        tbl[19] = mk(3'b000, 0, 0, 1, 3'b110, 2, 1, 1);
        tbl[20] = mk(3'b000, 0, 0, 1, 3'b110, 2, 1, 1);
        tbl[21] = mk(3'b000, 0, 0, 0, 3'b110, 2, 1, 1);
        tbl[22] = mk(3'b000, 1, 0, 0, 3'b000, 0, 0, 0);
        tbl[23] = mk(3'b011, 0, 1, 1, 3'b011, 1, 1, 0);
        tbl[24] = mk(3'b000, 0, 0, 1, 3'b011, 1, 1, 0);
        tbl[25] = mk(3'b100, 1, 1, 1, 3'b100, 1, 1, 2);
        tbl[26] = mk(3'b000, 0, 0, 1, 3'b100, 1, 1, 2);
        tbl[27] = mk(3'b001, 0, 1, 1, 3'b101, 2, 1, 2);
        tbl[28] = mk(3'b001, 1, 1, 1, 3'b001, 0, 0, 0);
        tbl[29] = mk(3'b001, 0, 1, 1, 3'b001, 0, 0, 0);
        tbl[30] = mk(3'b000, 0, 0, 1, 3'b001, 0, 0, 0);
        tbl[31] = mk(3'b100, 0, 1, 1, 3'b101, 1, 1, 2);

        for (int i = 0; i < 32; i++) begin
            in_vec = tbl[i].in;
            clr    = tbl[i].clr;
            step();
            chk_all($sformatf("row%0d", i), tbl[i].any, tbl[i].hold, tbl[i].sticky,
                    tbl[i].cnt, tbl[i].vld, tbl[i].idx);
        end
        clr = 1'b0;

        // Async reset while stretching: output must drop without a clock edge.
        in_vec = 3'b000;
        step();
        chk("pre_arst.hold", 32'(any_hold_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 1'b0, 1'b0, 3'b000, 8'd0, 1'b0, 2'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_arst.hold", 32'(any_hold_o), 32'd0);
        in_vec = 3'b001;
        step();
        chk("post_arst.cnt", 32'(evt_cnt_o), 32'd1);
        in_vec = 3'b000;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("post_arst.hold%0d", k), 32'(any_hold_o), (k <= 4) ? 32'd1 : 32'd0);
        end

        // Saturating 2-bit counter, HOLD=0 so hold tracks any_o.
        for (int k = 0; k < 5; k++) begin
            sat_in = 3'b001;
            step();
            chk($sformatf("sat.cnt%0d", k), 32'(sat_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
            chk($sformatf("sat.hold_hi%0d", k), 32'(sat_hold), 32'd1);
            sat_in = 3'b000;
            step();
            chk($sformatf("sat.hold_lo%0d", k), 32'(sat_hold), 32'd0);
        end

        // Random phase against the model.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic [2:0] v;
            logic       c;
            for (int b = 0; b < 3; b++) v[b] = ($urandom_range(3) == 0);
            c = ($urandom_range(15) == 0);
            in_vec = v;
            clr    = c;
            model_step(v, c);
            step();
            chk_all($sformatf("rnd%0d", n), m_any, (m_since <= 4), m_sticky, 8'(m_cnt),
                    m_vld, m_idx);
            if ($urandom_range(63) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
